// File: rtl/rf_pkg.sv
// =============================================================================
// Module   : rf_pkg
// Brief    : Shared constants, busy-vector type and address decode for rf_scoreboard
// Revision : 1.0
// =============================================================================
`default_nettype none

package rf_pkg;

    localparam int DEFAULT_DATA_W   = 4;
    localparam int DEFAULT_NUM_REGS = 4;
    localparam int ONEHOT_MAX       = 256;

    typedef logic [DEFAULT_NUM_REGS-1:0] busy_vec_t;

    // Callers truncate the result to their own register count.
    function automatic logic [ONEHOT_MAX-1:0] addr_onehot(input logic [31:0] addr);
        return {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << addr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_read_port.sv
// =============================================================================
// Module   : rf_read_port
// Brief    : Combinational read mux with write bypass and hardwired-zero handling
// Revision : 1.0
// =============================================================================
`default_nettype none

module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [NUM_REGS-1:0]             busy,
    input  logic [ADDR_W-1:0]               addr,
    input  logic                            wr_en,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    output logic [DATA_W-1:0]               data,
    output logic                            rdy
);

    localparam logic c_zero_en   = (ZERO_REG != 0);
    localparam logic c_bypass_en = (BYPASS != 0);

    logic w_zero;
    logic w_hit;

    assign w_zero = c_zero_en && (addr == '0);
    assign w_hit  = c_bypass_en && wr_en && (wr_addr == addr);

    // Zero register dominates the bypass path.
    assign data = w_zero ? '0 : (w_hit ? wr_data : regs[addr]);
    assign rdy  = w_zero || !busy[addr] || w_hit;

endmodule

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// =============================================================================
// Module   : rf_scoreboard
// Brief    : Register file with two read ports, one write port and pending-write scoreboard
// Revision : 1.0
// =============================================================================
`default_nettype none

module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   RA,
    input  logic [ADDR_W-1:0]   RB,
    output logic [DATA_W-1:0]   A,
    output logic [DATA_W-1:0]   B,
    output logic                A_RDY,
    output logic                B_RDY,
    input  logic                RE,
    input  logic [ADDR_W-1:0]   WR,
    input  logic [DATA_W-1:0]   WRD,
    input  logic                RSV,
    input  logic [ADDR_W-1:0]   RSV_ADDR,
    output logic                RSV_ACK,
    input  logic                FLUSH,
    output logic [NUM_REGS-1:0] BUSY
);

    localparam logic c_zero_en = (ZERO_REG != 0);
    // Register 0 never holds data or busy state when hardwired to zero.
    localparam logic [NUM_REGS-1:0] c_keep_mask =
        c_zero_en ? {{(NUM_REGS-1){1'b1}}, 1'b0} : {NUM_REGS{1'b1}};

    logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
    logic [NUM_REGS-1:0]             r_busy;
    logic [NUM_REGS-1:0]             w_wr_oh;
    logic [NUM_REGS-1:0]             w_rsv_oh;
    logic [NUM_REGS-1:0]             w_busy_next;
    logic                            w_rsv_zero;
    logic                            w_rsv_wr_hit;

    assign w_wr_oh = (RE ? NUM_REGS'(addr_onehot(32'(WR))) : '0) & c_keep_mask;

    assign w_rsv_zero   = c_zero_en && (RSV_ADDR == '0);
    assign w_rsv_wr_hit = RE && (WR == RSV_ADDR);
    assign RSV_ACK      = RSV && !FLUSH && (w_rsv_zero || !r_busy[RSV_ADDR] || w_rsv_wr_hit);

    assign w_rsv_oh = (RSV_ACK ? NUM_REGS'(addr_onehot(32'(RSV_ADDR))) : '0) & c_keep_mask;

    // Set after clear so a new producer supersedes a retiring one.
    assign w_busy_next = FLUSH ? '0 : ((r_busy & ~w_wr_oh) | w_rsv_oh);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_regs <= '0;
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_oh[i]) begin
                    r_regs[i] <= WRD;
                end
            end
            r_busy <= w_busy_next;
        end
    end

    assign BUSY = r_busy;

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_a (
        .regs     (r_regs),
        .busy     (r_busy),
        .addr     (RA),
        .wr_en    (RE),
        .wr_addr  (WR),
        .wr_data  (WRD),
        .data     (A),
        .rdy      (A_RDY)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_port_b (
        .regs     (r_regs),
        .busy     (r_busy),
        .addr     (RB),
        .wr_en    (RE),
        .wr_addr  (WR),
        .wr_data  (WRD),
        .data     (B),
        .rdy      (B_RDY)
    );

endmodule

`default_nettype wire

// File: doc/rf_scoreboard.md
Name: rf_scoreboard

Overview:
- Parametrised multi-register file with two combinational read ports, one write port, and a per-register pending-write scoreboard for simple in-order pipelines.
- Generalises the fixed 4x4-bit register set to NUM_REGS x DATA_W.
- Adds write-to-read bypass, an optional hardwired-zero register 0, and reserve/flush handshakes so the issue stage can detect RAW and WAW hazards.

Parameters:
- DATA_W, 4, width of each register and data port.
- NUM_REGS, 4, number of registers; power of two, minimum 2.
- ADDR_W, $clog2(NUM_REGS), register address width (derived; do not override).
- ZERO_REG, 0, when 1: register 0 always reads 0, writes to it are dropped, reserves to it never set busy.
- BYPASS, 1, when 1: a same-cycle write to a read address is forwarded to that read output.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- RA  in  ADDR_W  read port A address.
- RB  in  ADDR_W  read port B address.
- A  out  DATA_W  read port A data (combinational).
- B  out  DATA_W  read port B data (combinational).
- A_RDY  out  1  register RA has no pending writer (or is bypassed this cycle).
- B_RDY  out  1  same as A_RDY, for RB.
- RE  in  1  write enable.
- WR  in  ADDR_W  write address.
- WRD  in  DATA_W  write data.
- RSV  in  1  reserve request: mark register RSV_ADDR as pending.
- RSV_ADDR  in  ADDR_W  register to reserve.
- RSV_ACK  out  1  combinational; reserve accepted this cycle.
- FLUSH  in  1  synchronous clear of all busy bits.
- BUSY  out  NUM_REGS  registered scoreboard vector; bit i = register i pending.

Behaviour:
- Reset (reset=0, asynchronous): all registers set to 0; BUSY set to 0. A and B read 0, A_RDY=B_RDY=1. Reset takes effect mid-write, mid-reserve and mid-flush; no in-flight operation completes.
- Write: when RE=1, reg[WR] <= WRD on the rising edge.
  - With ZERO_REG=1 and WR=0, the write is dropped.
  - A write to a non-busy register is legal; it simply updates data.
- Read: A = reg[RA] with zero latency.
  - With BYPASS=1 and RE=1 and WR==RA (and not the ZERO_REG case), A = WRD instead.
  - With ZERO_REG=1 and RA=0, A = 0 regardless of bypass.
  - B follows identical rules using RB. RA==RB is legal; both ports return the same value.
- A_RDY = ~BUSY[RA] | (BYPASS & RE & WR==RA). A_RDY is forced 1 when ZERO_REG=1 and RA=0. B_RDY follows the same rule using RB.
- Scoreboard update, evaluated in priority order each edge:
  1. FLUSH=1: BUSY <= 0. RSV is ignored and RSV_ACK=0; writes still update data.
  2. Otherwise the write clears BUSY[WR] when RE=1.
  3. Otherwise the reserve sets BUSY[RSV_ADDR] when RSV_ACK=1.
  4. When the write and the reserve target the same register, the reserve wins and the bit ends at 1 (a new producer supersedes the old one).
- RSV_ACK = RSV & ~FLUSH & (~BUSY[RSV_ADDR] | (RE & WR==RSV_ADDR)).
  - A reserve of a busy register stalls (RSV_ACK=0, WAW hazard) unless that register is being written in the same cycle.
  - With ZERO_REG=1 and RSV_ADDR=0: RSV_ACK = RSV & ~FLUSH, and BUSY[0] stays 0.
- Latency: write data is visible on the next cycle through storage, or the same cycle through bypass. BUSY changes one cycle after the request.
- The block does not check writes against reservations; the issue stage owns ordering.

Decomposition:
- Shared package rf_pkg holds:
  - default DATA_W and NUM_REGS constants;
  - a function for the address-decode one-hot, replacing the hand-written case decode;
  - typedef for the BUSY vector.
- One natural sub-module, rf_read_port: address mux plus bypass and zero-register logic. Instantiated twice (A, B).
- Storage and the scoreboard stay in the top level.

Test Plan:
- Reset release, then write reg2=0xA (RE=1, WR=2, WRD=0xA) and read RA=2 next cycle → A=0xA. Assert reset mid-write → all regs 0, BUSY=0.
- RSV=1, RSV_ADDR=3 → RSV_ACK=1, BUSY=4'b1000 next cycle, RA=3 gives A_RDY=0. Then RE=1, WR=3, WRD=0x5 with RA=3 → same cycle A=0x5, A_RDY=1; next cycle BUSY=0.
- With BUSY[1]=1, RSV to reg1 with RE=0 → RSV_ACK=0, BUSY unchanged. Repeat with RE=1, WR=1 same cycle → RSV_ACK=1, BUSY[1] stays 1.
- FLUSH=1 with BUSY=4'b0110 and RSV=1 to reg0 → RSV_ACK=0, BUSY=0 next cycle, register data unchanged.
- ZERO_REG=1, NUM_REGS=8, DATA_W=8: write 0xFF to reg0, read RA=0 → A=0x00, A_RDY=1. Reserve reg0 → RSV_ACK=1, BUSY[0]=0.
- BYPASS=0: RE=1, WR=RA=1, WRD=0x3, old value 0x9 → A=0x9 this cycle, 0x3 next cycle, A_RDY follows BUSY only.
